// File: rtl/cam_std_monitor.sv
// cam_std_monitor
//   Measures TVP5150 video timing in the camera pixel-clock domain and
//   publishes stable per-field diagnostics: active luma samples of the last
//   complete line, complete lines per field, PAL/NTSC class, lock state,
//   lock-loss count and a missing-field watchdog.
//
//   Optional build macro: CAM_STD_MON_WATCHDOG_EN
//     defined   -> watchdog counter built; a field-less interval of
//                  TIMEOUT_CLKS cycles raises timeout_flag and drops lock.
//     undefined -> no watchdog; timeout_flag is constant 0.
//
// Ports
//   cam1_pclk         in   pixel clock
//   cam_resetn        in   asynchronous active-low reset
//   line_valid        in   active-line qualifier
//   y_valid           in   luma sample strobe
//   field_toggle      in   toggles once per field
//   samples_per_line  out  [10:0] samples of last complete line of prev field
//   lines_per_field   out  [9:0]  complete lines in previous field
//   std_code          out  [1:0]  0 unknown, 1 NTSC, 2 PAL
//   locked            out  lock state machine is in LOCKED
//   lock_loss_cnt     out  [15:0] LOCKED->SEARCH transitions, saturating
//   timeout_flag      out  sticky until the next field edge
//   new_field         out  one-cycle pulse when the outputs are updated
module cam_std_monitor #(
  parameter int LINE_TOL     = 2,
  parameter int SAMP_TOL     = 4,
  parameter int LOCK_FIELDS  = 8,    // up to 256
  parameter int MISS_FIELDS  = 3,    // up to 256
  parameter int TIMEOUT_CLKS = 1350000
) (
  input  logic        cam1_pclk,
  input  logic        cam_resetn,
  input  logic        line_valid,
  input  logic        y_valid,
  input  logic        field_toggle,
  output logic [10:0] samples_per_line,
  output logic [9:0]  lines_per_field,
  output logic [1:0]  std_code,
  output logic        locked,
  output logic [15:0] lock_loss_cnt,
  output logic        timeout_flag,
  output logic        new_field
);
  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [11:0] LTOL      = 12'(LINE_TOL);
  localparam logic [11:0] STOL      = 12'(SAMP_TOL);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FIELDS - 1);
  localparam logic [7:0]  MISS_LAST = 8'(MISS_FIELDS - 1);

  state_t      state;
  logic        ft_d, lv_d, seen_field;
  logic        fe, le, match, wd_hit;
  logic [10:0] scnt, scnt_inc, last_line_samp, samp_now;
  logic [9:0]  lcnt, lines_now;
  logic [7:0]  match_cnt, miss_cnt;
  logic [11:0] dlines, dsamp, alines, asamp;
  logic [1:0]  std_next;

  assign fe = field_toggle ^ ft_d;
  assign le = lv_d & ~line_valid;

  // Sample count including this cycle's strobe, saturating at 2047.
  assign scnt_inc = (line_valid && y_valid && scnt != 11'h7FF) ? scnt + 11'd1 : scnt;

  // A line ending in the field-edge cycle belongs to the ending field.
  assign samp_now  = le ? scnt_inc : last_line_samp;
  assign lines_now = (le && lcnt != 10'h3FF) ? lcnt + 10'd1 : lcnt;

  // 12-bit signed differences cannot wrap for 10/11-bit operands.
  assign dlines = {2'b00, lines_now} - {2'b00, lines_per_field};
  assign dsamp  = {1'b0, samp_now} - {1'b0, samples_per_line};
  assign alines = dlines[11] ? -dlines : dlines;
  assign asamp  = dsamp[11] ? -dsamp : dsamp;

  // The first field after reset has nothing real to compare against.
  assign match = seen_field && (alines <= LTOL) && (asamp <= STOL);

  always_comb begin
    std_next = 2'd0;
    if (lines_now >= 10'd235 && lines_now <= 10'd250)      std_next = 2'd1;
    else if (lines_now >= 10'd280 && lines_now <= 10'd295) std_next = 2'd2;
  end

  assign locked = (state == LOCKED);

`ifdef CAM_STD_MON_WATCHDOG_EN
  localparam int             WW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CLKS);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CLKS - 1);
  logic [WW-1:0] wd_cnt;

  // Fires only on the step into saturation, so once per idle episode.
  assign wd_hit = !fe && (wd_cnt == WD_LAST);

  always_ff @(posedge cam1_pclk or negedge cam_resetn)
    if (!cam_resetn)          wd_cnt <= '0;
    else if (fe)              wd_cnt <= '0;
    else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
`else
  assign wd_hit = 1'b0;
`endif

  // Line / sample measurement.
  always_ff @(posedge cam1_pclk or negedge cam_resetn)
    if (!cam_resetn) begin
      ft_d           <= 1'b0;
      lv_d           <= 1'b0;
      scnt           <= '0;
      last_line_samp <= '0;
      lcnt           <= '0;
      new_field      <= 1'b0;
    end else begin
      ft_d      <= field_toggle;
      lv_d      <= line_valid;
      new_field <= fe;
      if (le) begin
        scnt           <= '0;
        last_line_samp <= scnt_inc;
      end else begin
        scnt <= scnt_inc;
      end
      // An open line at the edge is counted when it ends, in the new field.
      if (fe)                       lcnt <= '0;
      else if (le && lcnt != 10'h3FF) lcnt <= lcnt + 10'd1;
    end

  // Field latch, lock state machine and watchdog reaction.
  always_ff @(posedge cam1_pclk or negedge cam_resetn)
    if (!cam_resetn) begin
      state            <= SEARCH;
      match_cnt        <= '0;
      miss_cnt         <= '0;
      seen_field       <= 1'b0;
      samples_per_line <= '0;
      lines_per_field  <= '0;
      std_code         <= '0;
      lock_loss_cnt    <= '0;
      timeout_flag     <= 1'b0;
    end else if (fe) begin
      samples_per_line <= samp_now;
      lines_per_field  <= lines_now;
      std_code         <= std_next;
      seen_field       <= 1'b1;
      timeout_flag     <= 1'b0;
      case (state)
        SEARCH:
          if (!match) match_cnt <= '0;
          else if (match_cnt == LOCK_LAST) begin
            state     <= LOCKED;
            match_cnt <= '0;
          end else match_cnt <= match_cnt + 8'd1;
        LOCKED:
          if (match) miss_cnt <= '0;
          else if (miss_cnt == MISS_LAST) begin
            state    <= SEARCH;
            miss_cnt <= '0;
            if (lock_loss_cnt != 16'hFFFF) lock_loss_cnt <= lock_loss_cnt + 16'd1;
          end else miss_cnt <= miss_cnt + 8'd1;
        default: state <= SEARCH;
      endcase
    end else if (wd_hit) begin
      timeout_flag     <= 1'b1;
      state            <= SEARCH;
      match_cnt        <= '0;
      miss_cnt         <= '0;
      samples_per_line <= '0;
      lines_per_field  <= '0;
      std_code         <= '0;
      if (state == LOCKED && lock_loss_cnt != 16'hFFFF)
        lock_loss_cnt <= lock_loss_cnt + 16'd1;
    end
endmodule

// File: tb/tb_cam_std_monitor.sv
// Testbench for cam_std_monitor: a transaction-level driver builds fields
// out of lines, records each field edge with the line/sample totals it must
// report, and a per-cycle checker derives every output from those records.
module tb_cam_std_monitor;
  localparam int LT = 2, ST = 4, LF = 8, MF = 3, TO = 3000;

  logic        cam1_pclk = 1'b0, cam_resetn = 1'b0;
  logic        line_valid = 1'b0, y_valid = 1'b0, field_toggle = 1'b0;
  logic [10:0] samples_per_line;
  logic [9:0]  lines_per_field;
  logic [1:0]  std_code;
  logic        locked, timeout_flag, new_field;
  logic [15:0] lock_loss_cnt;

  cam_std_monitor #(.LINE_TOL(LT), .SAMP_TOL(ST), .LOCK_FIELDS(LF),
                    .MISS_FIELDS(MF), .TIMEOUT_CLKS(TO)) dut (
    .cam1_pclk(cam1_pclk), .cam_resetn(cam_resetn), .line_valid(line_valid),
    .y_valid(y_valid), .field_toggle(field_toggle),
    .samples_per_line(samples_per_line), .lines_per_field(lines_per_field),
    .std_code(std_code), .locked(locked), .lock_loss_cnt(lock_loss_cnt),
    .timeout_flag(timeout_flag), .new_field(new_field));

  always #5 cam1_pclk = ~cam1_pclk;

  int cyc = 0;
  always @(posedge cam1_pclk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  typedef struct { int c; int lines; int samp; } ev_t;
  ev_t evq[$];
  int  cur_lines = 0, last_samp = 0, hmax = 0;

  // Reference model state
  int m_lines = 0, m_samp = 0, m_std = 0, m_mc = 0, m_ms = 0, m_loss = 0, wd_ref = 0;
  bit m_locked = 0, m_flag = 0, m_nf = 0, m_first = 0, m_fired = 0, prev_rst = 0;

  task automatic apply_field(input int l, input int s);
    int dl, ds;
    bit m;
    dl = l - m_lines; ds = s - m_samp;
    if (dl < 0) dl = -dl;
    if (ds < 0) ds = -ds;
    m = m_first && dl <= LT && ds <= ST;
    m_first = 1; m_lines = l; m_samp = s;
    m_std = (l >= 235 && l <= 250) ? 1 : (l >= 280 && l <= 295) ? 2 : 0;
    if (!m_locked) begin
      if (m) begin
        m_mc++;
        if (m_mc == LF) begin m_locked = 1; m_mc = 0; end
      end else m_mc = 0;
    end else if (m) m_ms = 0;
    else begin
      m_ms++;
      if (m_ms == MF) begin
        m_locked = 0; m_ms = 0;
        if (m_loss < 65535) m_loss++;
      end
    end
    m_flag = 0; m_fired = 0; m_nf = 1; wd_ref = cyc;
  endtask

  always @(negedge cam1_pclk) begin : cmp
    ev_t e;
    bit  bad;
    m_nf = 0;
    if (!cam_resetn) begin
      m_lines = 0; m_samp = 0; m_std = 0; m_mc = 0; m_ms = 0; m_loss = 0;
      m_locked = 0; m_flag = 0; m_first = 0; m_fired = 0;
      evq.delete();
    end else begin
      if (!prev_rst) wd_ref = cyc;
      if (evq.size() > 0 && evq[0].c + 1 == cyc) begin
        e = evq.pop_front();
        apply_field(e.lines, e.samp);
      end
`ifdef CAM_STD_MON_WATCHDOG_EN
      if (!m_fired && cyc == wd_ref + TO) begin
        m_fired = 1; m_flag = 1;
        if (m_locked && m_loss < 65535) m_loss++;
        m_locked = 0; m_mc = 0; m_ms = 0;
        m_lines = 0; m_samp = 0; m_std = 0;
      end
`endif
    end
    prev_rst = cam_resetn;
    checks++;
    bad = (samples_per_line !== 11'(m_samp)) || (lines_per_field !== 10'(m_lines)) ||
          (std_code !== 2'(m_std)) || (locked !== m_locked) ||
          (lock_loss_cnt !== 16'(m_loss)) || (timeout_flag !== m_flag) ||
          (new_field !== m_nf);
    if (bad) begin
      errors++;
      $display("FAIL cycle %0d outputs: got spl=%0d lpf=%0d std=%0d lk=%0d loss=%0d to=%0d nf=%0d, expected spl=%0d lpf=%0d std=%0d lk=%0d loss=%0d to=%0d nf=%0d",
               cyc, samples_per_line, lines_per_field, std_code, locked, lock_loss_cnt,
               timeout_flag, new_field, m_samp, m_lines, m_std, m_locked, m_loss, m_flag, m_nf);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cam1_pclk);
    #1;
  endtask

  task automatic toggle();
    field_toggle = ~field_toggle;
    evq.push_back('{cyc, (cur_lines > 1023) ? 1023 : cur_lines, last_samp});
    cur_lines = 0;
  endtask

  // mode: 0 no edge, 1 edge mid-line, 2 edge on the line-end cycle, 3 edge in the gap
  task automatic drive_line(input int ns, input int mode);
    int holes, total, got, mid, rs, rc;
    holes = (hmax > 0) ? $urandom_range(0, hmax) : 0;
    total = ns + holes; got = 0; mid = total / 2;
    for (int i = 0; i < total; i++) begin
      step();
      line_valid = 1'b1;
      rs = ns - got; rc = total - i;
      y_valid = (rs == rc) ? 1'b1 : (rs == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      got += int'(y_valid);
      if (mode == 1 && i == mid) toggle();
    end
    step();
    line_valid = 1'b0; y_valid = 1'b0;
    cur_lines++;
    last_samp = (ns > 2047) ? 2047 : ns;
    if (mode == 2) toggle();
    step();
    if (mode == 3) toggle();
  endtask

  task automatic field(input int nl, input int ns, input int mode);
    if (nl == 0) begin step(); toggle(); end
    for (int i = 0; i < nl; i++) drive_line(ns, (i == nl - 1) ? mode : 0);
  endtask

  task automatic wait_nf();
    bit got;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge cam1_pclk);
      if (new_field) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL new_field_wait: got no pulse expected pulse within 4 cycles");
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL guard: got time limit expected $finish");
    $fatal(1, "simulation time limit");
  end

  int pal[6] = '{288, 290, 288, 290, 288, 291};
  int base, lb;

  initial begin
    repeat (3) @(posedge cam1_pclk);
    @(negedge cam1_pclk);
    chk("reset_lpf", lines_per_field, 0);
    chk("reset_spl", samples_per_line, 0);
    chk("reset_std", std_code, 0);
    chk("reset_lock", locked, 0);
    chk("reset_loss", lock_loss_cnt, 0);
    chk("reset_nf", new_field, 0);
    step(); cam_resetn = 1'b1;

    // Stable NTSC: first field mismatches, lock on the 9th
    for (int i = 0; i < 10; i++) begin
      field(243, 4, 3); wait_nf();
      if (i == 7) chk("ntsc_prelock", locked, 0);
      if (i == 8) chk("ntsc_lock", locked, 1);
    end
    chk("ntsc_std", std_code, 1);
    chk("ntsc_loss", lock_loss_cnt, 0);
    chk("ntsc_lpf", lines_per_field, 243);
    chk("ntsc_spl", samples_per_line, 4);

    // PAL tolerance while locked
    for (int i = 0; i < 6; i++) begin
      field(pal[i], 4, 3); wait_nf();
      chk("pal_stay_locked", locked, 1);
    end
    chk("pal_std", std_code, 2);

    // Loss: three mismatching fields in a row
    field(289, 4, 3); field(200, 4, 3); field(200, 10, 3); wait_nf();
    chk("loss_two_miss", locked, 1);
    field(200, 4, 3); wait_nf();
    chk("loss_unlock", locked, 0);
    chk("loss_cnt", lock_loss_cnt, 1);
    chk("loss_std", std_code, 0);

    // Boundary coincidence and open line at the edge
    field(250, 2, 2); wait_nf();
    chk("coincide_lpf", lines_per_field, 250);
    chk("coincide_std", std_code, 1);
    field(240, 2, 1);
    chk("open_line_lpf", lines_per_field, 239);
    field(240, 2, 3); wait_nf();
    chk("carried_line_lpf", lines_per_field, 241);

    // Saturation
    field(1, 2100, 3); wait_nf();
    chk("sat_spl", samples_per_line, 2047);
    chk("sat_one_line", lines_per_field, 1);
    field(1100, 1, 3); wait_nf();
    chk("sat_lpf", lines_per_field, 1023);

    // Randomized jittered fields, random edge placement
    hmax = 1;
    base = ($urandom_range(0, 1) == 0) ? 236 : 281;
    for (int i = 0; i < 12; i++)
      field(base + $urandom_range(0, 3), 3 + $urandom_range(0, 1), $urandom_range(1, 3));
    hmax = 0;

    // Watchdog
    for (int i = 0; i < 10; i++) field(10, 3, 3);
    wait_nf();
    chk("wd_prelock", locked, 1);
    lb = m_loss;
    repeat (TO + 5) step();
`ifdef CAM_STD_MON_WATCHDOG_EN
    chk("wd_flag", timeout_flag, 1);
    chk("wd_unlock", locked, 0);
    chk("wd_loss", lock_loss_cnt, lb + 1);
    chk("wd_lpf", lines_per_field, 0);
    repeat (5000) step();
    chk("wd_once", lock_loss_cnt, lb + 1);
`else
    chk("wd_flag_off", timeout_flag, 0);
    chk("wd_off_lock", locked, 1);
    repeat (5000) step();
    chk("wd_off_loss", lock_loss_cnt, lb);
`endif
    step(); toggle(); wait_nf();
    chk("wd_flag_clear", timeout_flag, 0);

    // Reset mid-line with field_toggle high at release
    step(); line_valid = 1'b1; y_valid = 1'b1;
    repeat (5) step();
    cam_resetn = 1'b0; field_toggle = 1'b1; line_valid = 1'b0; y_valid = 1'b0;
    cur_lines = 0; last_samp = 0;
    @(negedge cam1_pclk);
    chk("midrst_lpf", lines_per_field, 0);
    chk("midrst_loss", lock_loss_cnt, 0);
    step(); cam_resetn = 1'b1;
    evq.push_back('{cyc, 0, 0});
    wait_nf();
    chk("rel_edge_lpf", lines_per_field, 0);
    chk("rel_edge_lock", locked, 0);
    field(243, 3, 3); wait_nf();
    chk("post_rst_lpf", lines_per_field, 243);
    chk("post_rst_std", std_code, 1);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
